melody_seq: RTL and testbench
=============================

// Module: melody_seq
// PURPOSE
//  Note sequencer for the tone generator. Holds a programmable table of
//  {ton, duration} entries and steps through it, driving the generator's
//  ton select and en. Sits between the control/register logic and the
//  tone generator. One clock; reset is asynchronous and active-low.
// PARAMETERS
//  TICK_DIV   50000  clk cycles per duration tick (1 ms at 50 MHz); >=2
//  NOTES      16     table depth; power of two; index width IW=$clog2(NOTES)
//  DUR_W      8      duration field width, in ticks
//  GAP_TICKS  10     silent ticks between notes (MELODY_GAP_EN only); >=1
// PORTS
//  clk       in   1        system clock
//  rst_n     in   1        asynchronous reset, active low
//  start     in   1        pulse: play from entry 0 (ignored while busy)
//  stop      in   1        abort playback; overrides start in the same cycle
//  loop      in   1        1 = at terminator restart from entry 0
//  wr_en     in   1        table write strobe
//  wr_addr   in   IW       table write address
//  wr_data   in   4+DUR_W  {ton[3:0], dur[DUR_W-1:0]}
//  ton       out  4        tone select to generator (registered)
//  en        out  1        generator enable (registered)
//  busy      out  1        high in any state except IDLE
//  done      out  1        1-cycle pulse at natural end of melody
//  note_idx  out  IW       index of current entry
// BEHAVIOUR
//  Reset: ton=0, en=0, busy=0, done=0, note_idx=0, state IDLE, prescaler 0;
//   table contents are not reset.
//  Table: write-first single port; writes allowed while busy, seen the
//   next time that entry is loaded. dur==0 is the terminator.
//  ton==0 is a rest: entry is timed normally but en stays 0.
//  States:
//   IDLE : en=0, ton=0. start & !stop -> LOAD, note_idx=0, prescaler=0.
//   LOAD : read entry[note_idx]. dur!=0 -> PLAY, cnt=dur, ton=entry ton,
//          en=(ton!=0). dur==0: loop & note_idx!=0 -> LOAD, note_idx=0;
//          else -> DONE (all-terminator table never spins).
//   PLAY : cnt decrements on each tick (prescaler wrap, every TICK_DIV
//          clks). On the tick where cnt==1: en=0, ton=0, note_idx+1
//          (wraps NOTES-1 -> 0) -> GAP if MELODY_GAP_EN, else LOAD.
//          Wrap past NOTES-1 with no terminator behaves as terminator
//          (loop -> index 0 continues, else -> DONE).
//   DONE : done=1 for one cycle, -> IDLE.
//  Latency: start at cycle N -> en=1 (sounding ton) at cycle N+2.
//  Note length: dur*TICK_DIV clks of PLAY, +/-0; prescaler restarts on
//   start only, not per note.
//  Without gap, consecutive notes have en low for exactly 1 cycle (LOAD).
//  stop: any state -> IDLE next cycle, en=0, ton=0, no done pulse.
//  Reset mid-play: outputs clear immediately (async).
// CONFIGURATION
//  MELODY_GAP_EN defined: state GAP inserted after each note; en=0 for
//   GAP_TICKS ticks, then LOAD. Articulates repeated identical notes.
//  Not defined: no GAP state, no gap counter; PLAY -> LOAD directly.
// STRUCTURE
//  melody_pkg: state enum (IDLE, LOAD, PLAY, GAP, DONE), entry struct
//   {ton, dur}, TON_REST=4'd0 constant.
//  Sub-module tick_prescaler (TICK_DIV): count, clear input, tick pulse.
//  Table is a NOTES x (4+DUR_W) register array inside melody_seq.
// TESTING (TICK_DIV=4, NOTES=4, GAP off unless stated)
//  1 table {1,3},{0,2},{1,1},{x,0}; start -> en=1 12 clks, en=0 rest 8
//    clks + LOAD, en=1 4 clks, done pulse, busy falls next cycle.
//  2 same table, loop=1 -> after entry 2 restarts at idx 0; stop mid
//    entry 1 -> IDLE next cycle, en=0, no done.
//  3 all entries {1,2}, loop=0 -> idx wraps 3->0, treated as terminator,
//    done after 4 notes; loop=1 -> plays continuously.
//  4 entry0 dur=0, loop=1 -> done pulse 2 cycles after start, no spin.
//  5 start+stop same cycle -> stays IDLE; start while busy -> ignored;
//    rst_n low mid-PLAY -> en=0 asynchronously.
//  6 MELODY_GAP_EN, GAP_TICKS=2, table {1,1},{1,1},{x,0} -> en high 4,
//    low 8 (+LOAD), high 4, done.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: FSM states, table entry layout, rest code.
// The optional inter-note gap is selected with the MELODY_GAP_EN macro.
package melody_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int DUR_W_DEF = 8;

  typedef struct packed {
    logic [3:0]           ton;
    logic [DUR_W_DEF-1:0] dur;
  } entry_t;

  localparam logic [3:0] TON_REST = 4'd0;

endpackage

// File: rtl/melody_seq_if.sv
// Control-side bundle of the melody sequencer: commands and table writes in,
// tone-generator drive and status out.
interface melody_seq_if #(
    parameter int NOTES = 16,
    parameter int DUR_W = 8
);
    localparam int IW = $clog2(NOTES);

    // No valid/ready pair: start, stop and wr_en are single-cycle strobes sampled
    // on every rising clock edge; the sequencer never back-pressures the master.
    logic              start;
    logic              stop;
    logic              loop;
    logic              wr_en;
    logic [IW-1:0]     wr_addr;
    logic [3+DUR_W:0]  wr_data;
    logic [3:0]        ton;
    logic              en;
    logic              busy;
    logic              done;
    logic [IW-1:0]     note_idx;

    modport master (
        output start, stop, loop, wr_en, wr_addr, wr_data,
        input  ton, en, busy, done, note_idx
    );

    modport slave (
        input  start, stop, loop, wr_en, wr_addr, wr_data,
        output ton, en, busy, done, note_idx
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle duration ticks; counts only while enabled so
// note lengths stay exact across the one-cycle LOAD between notes.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/melody_seq.sv
// Note sequencer: steps a {ton, dur} table and drives the tone generator.
// Define MELODY_GAP_EN to insert GAP_TICKS silent ticks after every note.
module melody_seq
    import melody_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int NOTES    = 16,
    parameter int DUR_W    = 8
`ifdef MELODY_GAP_EN
    , parameter int GAP_TICKS = 10
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    melody_seq_if.slave  bus,
    output state_t       dbg_state
);

    localparam int IW = $clog2(NOTES);
    localparam int EW = 4 + DUR_W;

    logic [EW-1:0]    note_tab [NOTES];
    logic [EW-1:0]    rd_word;
    logic [3:0]       rd_ton;
    logic [DUR_W-1:0] rd_dur;

    state_t           state;
    logic [DUR_W-1:0] cnt;
    logic [IW-1:0]    idx;
    logic [3:0]       ton_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;

    logic             start_go;
    logic             pre_en;
    logic             tick;
    logic             last_idx;

`ifdef MELODY_GAP_EN
    localparam int GW = $clog2(GAP_TICKS + 1);
    logic [GW-1:0] gap_cnt;
`endif

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            note_tab[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Write-first: an entry written in the same cycle it is loaded is used as new.
    assign rd_word          = (bus.wr_en && (bus.wr_addr == idx)) ? bus.wr_data : note_tab[idx];
    assign {rd_ton, rd_dur} = rd_word;

    assign start_go = (state == ST_IDLE) && bus.start && !bus.stop;
    assign pre_en   = (state == ST_PLAY) || (state == ST_GAP);
    assign last_idx = (idx == IW'(NOTES - 1));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_go),
        .en    (pre_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            ton_q   <= TON_REST;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MELODY_GAP_EN
            gap_cnt <= '0;
`endif
        end else if (bus.stop) begin
            state  <= ST_IDLE;
            ton_q  <= TON_REST;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        state  <= ST_LOAD;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (rd_dur != '0) begin
                        state <= ST_PLAY;
                        cnt   <= rd_dur;
                        ton_q <= rd_ton;
                        en_q  <= (rd_ton != TON_REST);
                    end else if (bus.loop && (idx != '0)) begin
                        idx <= '0;
                    end else begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (cnt == DUR_W'(1)) begin
                            en_q  <= 1'b0;
                            ton_q <= TON_REST;
                            idx   <= idx + 1'b1;
                            // Running off the end of the table acts as a terminator.
                            if (last_idx && !bus.loop) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
`ifdef MELODY_GAP_EN
                                state   <= ST_GAP;
                                gap_cnt <= GW'(GAP_TICKS);
`else
                                state   <= ST_LOAD;
`endif
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
`ifdef MELODY_GAP_EN
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GW'(1)) begin
                            state <= ST_LOAD;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ton      = ton_q;
    assign bus.en       = en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.note_idx = idx;
    assign dbg_state    = state;

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: a note table is expanded into the expected per-cycle
// output trace and compared cycle by cycle against the sequencer.
`timescale 1ns/1ps
module tb_melody_seq;
    import melody_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int NOTES    = 4;
    localparam int DUR_W    = 8;
    localparam int IW       = 2;
`ifdef MELODY_GAP_EN
    localparam int GAP_TICKS = 2;
`else
    localparam int GAP_TICKS = 0;
`endif
    localparam int W = 3 + 4 + IW;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t         tab [NOTES];
    logic [W-1:0]   exp_q [$];

    melody_seq_if #(.NOTES(NOTES), .DUR_W(DUR_W)) bus ();

    melody_seq #(
        .TICK_DIV (TICK_DIV),
        .NOTES    (NOTES),
        .DUR_W    (DUR_W)
`ifdef MELODY_GAP_EN
        , .GAP_TICKS (GAP_TICKS)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] obs();
        return {bus.busy, bus.done, bus.en, bus.ton, bus.note_idx};
    endfunction

    // ---------------- reference model ----------------
    function automatic void push(input bit b, input bit d, input bit e, input logic [3:0] t, input int i);
        exp_q.push_back({b, d, e, t, IW'(i)});
    endfunction

    // Expands the table into the outputs seen on each cycle after the start edge.
    function automatic void build_trace(input bit lp, input int cap);
        int idx;
        bit fin;
        bit wrap;
        exp_q.delete();
        idx = 0;
        fin = 0;
        push(1, 0, 0, 4'd0, 0);
        while (!fin && exp_q.size() < cap) begin
            if (tab[idx].dur == 0) begin
                if (lp && idx != 0) begin
                    idx = 0;
                    push(1, 0, 0, 4'd0, idx);
                end else begin
                    push(1, 1, 0, 4'd0, idx);
                    push(0, 0, 0, 4'd0, idx);
                    fin = 1;
                end
            end else begin
                for (int c = 0; c < int'(tab[idx].dur) * TICK_DIV; c++)
                    push(1, 0, tab[idx].ton != 0, tab[idx].ton, idx);
                wrap = (idx == NOTES - 1);
                idx  = (idx + 1) % NOTES;
                if (wrap && !lp) begin
                    push(1, 1, 0, 4'd0, idx);
                    push(0, 0, 0, 4'd0, idx);
                    fin = 1;
                end else begin
                    for (int c = 0; c < GAP_TICKS * TICK_DIV; c++)
                        push(1, 0, 0, 4'd0, idx);
                    push(1, 0, 0, 4'd0, idx);
                end
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic write_table();
        for (int i = 0; i < NOTES; i++) begin
            @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_addr = IW'(i);
            bus.wr_data = {tab[i].ton, tab[i].dur};
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic set_tab(input int i, input int t, input int d);
        tab[i].ton = 4'(t);
        tab[i].dur = 8'(d);
    endtask

    task automatic play(input string tag, input bit lp, input int stop_at, input bit spurious, input int cap);
        int k;
        bit stopped;
        logic [W-1:0] e;
        build_trace(lp, cap);
        @(negedge clk);
        bus.loop  = lp;
        bus.start = 1'b1;
        k = 0;
        stopped = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            k++;
            check(tag, 32'(obs()), 32'(e));
            bus.start = spurious && e[W-1] && ($urandom_range(0, 7) == 0);
            if (k == stop_at) begin
                bus.stop = 1'b1;
                stopped  = 1;
                exp_q.delete();
            end
        end
        bus.start = 1'b0;
        if (stopped) begin
            @(negedge clk);
            bus.stop = 1'b0;
            check({tag, "_stop"}, 32'({bus.busy, bus.done, bus.en, bus.ton}), 32'd0);
            check({tag, "_stop_state"}, 32'(dbg_state), 32'(ST_IDLE));
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check({tag, "_no_done"}, 32'({bus.busy, bus.done}), 32'd0);
            end
        end
    endtask

    task automatic table_t1();
        set_tab(0, 1, 3);
        set_tab(1, 0, 2);
        set_tab(2, 1, 1);
        set_tab(3, 5, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start = 0; bus.stop = 0; bus.loop = 0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(obs()), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel", 32'(obs()), 32'd0);

        // basic melody with a rest and a terminator
        table_t1();
        write_table();
        play("t1", 0, 0, 0, 400);

        // looping, stopped in the middle of the second pass over the rest
        play("t2_loop", 1, 46, 0, 400);

        // no terminator: index wraps and ends, or loops continuously
        for (int i = 0; i < NOTES; i++) set_tab(i, 1, 2);
        write_table();
        play("t3_wrap", 0, 0, 0, 400);
        play("t3_loop", 1, 100, 0, 400);

        // terminator at entry 0 with loop set must not spin
        set_tab(0, 3, 0);
        write_table();
        play("t4_term0", 1, 0, 0, 50);

        // start and stop together never leave IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("t5_startstop", 32'({bus.busy, bus.en}), 32'd0);
        @(negedge clk);
        check("t5_startstop_state", 32'(dbg_state), 32'(ST_IDLE));

        // asynchronous reset while a note sounds; table survives reset
        table_t1();
        write_table();
        @(negedge clk);
        bus.start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("t5_pre_rst_en", 32'(bus.en), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("t5_async_rst", 32'(obs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        play("t5_after_rst", 0, 0, 1, 400);

        // two short identical notes (articulated when the gap is built in)
        set_tab(0, 1, 1);
        set_tab(1, 1, 1);
        set_tab(2, 7, 0);
        set_tab(3, 2, 1);
        write_table();
        play("t6_pair", 0, 0, 0, 200);

        // randomized tables, loop, stop point and ignored start pulses
        for (int r = 0; r < 25; r++) begin
            int st;
            bit lp;
            for (int i = 0; i < NOTES; i++)
                set_tab(i, $urandom_range(0, 15), ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
            write_table();
            lp = 1'($urandom_range(0, 1));
            if (lp) st = $urandom_range(5, 150);
            else    st = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 40) : 0;
            play("rand", lp, st, 1, 400);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
